// File: rtl/ld_st_hazard_resolver.sv
// LD/ST hazard resolver: stalls on load-use hazards and forwards execute/load data to the decode consumer.
// Optional operand forwarding is enabled by defining HAZARD_FWD_EN; without it every hazard is resolved by stalling.
module ld_st_hazard_resolver #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             i_detect,
  input  logic                   i_ex_is_ld,
  input  logic [15:0]            i_ex_result,
  input  logic [15:0]            i_mem_rdata,
  input  logic                   i_mem_rdata_valid,
  input  logic                   i_flush,
  output logic                   o_stall,
  output logic                   o_bubble,
  output logic                   o_fwd_rx,
  output logic                   o_fwd_ry,
  output logic [15:0]            o_fwd_data,
  output logic [STALL_CNT_W-1:0] o_stall_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    FWD      = 2'd2
`ifndef HAZARD_FWD_EN
    , STALL_WB = 2'd3
`endif
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  state_t state, state_nxt;
  logic   stall;
  logic   fwd_rx, fwd_ry;
  logic   hazard;

  assign hazard = |i_detect;

`ifdef HAZARD_FWD_EN
  logic [1:0]  mask, mask_nxt;
  logic [15:0] fwd_data_nxt;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    mask_nxt     = mask;
    fwd_data_nxt = o_fwd_data;
    stall        = 1'b0;
    fwd_rx       = 1'b0;
    fwd_ry       = 1'b0;
    case (state)
      IDLE, FWD: begin
        if (state == FWD) begin
          fwd_rx = mask[0];
          fwd_ry = mask[1];
        end
        state_nxt = IDLE;
        if (hazard) begin
          mask_nxt = i_detect;
          if (i_ex_is_ld) begin
            stall     = 1'b1;
            state_nxt = WAIT_MEM;
          end else begin
            fwd_data_nxt = i_ex_result;
            state_nxt    = FWD;
          end
        end
      end
      WAIT_MEM: begin
        if (i_mem_rdata_valid) begin
          fwd_data_nxt = i_mem_rdata;
          state_nxt    = FWD;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A taken branch kills the consumer, so any pending capture or stall is dropped.
    if (i_flush) begin
      state_nxt    = IDLE;
      mask_nxt     = mask;
      fwd_data_nxt = o_fwd_data;
      stall        = 1'b0;
    end
    if (!reset_n) begin
      stall  = 1'b0;
      fwd_rx = 1'b0;
      fwd_ry = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask       <= 2'b00;
      o_fwd_data <= 16'h0000;
    end else begin
      mask       <= mask_nxt;
      o_fwd_data <= fwd_data_nxt;
    end
  end
`else
  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{i_ex_result, i_mem_rdata};
  assign o_fwd_data        = 16'h0000;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    fwd_rx    = 1'b0;
    fwd_ry    = 1'b0;
    case (state)
      IDLE: begin
        if (hazard) begin
          stall     = 1'b1;
          state_nxt = i_ex_is_ld ? WAIT_MEM : STALL_WB;
        end
      end
      WAIT_MEM: begin
        if (i_mem_rdata_valid) state_nxt = STALL_WB;
        else                   stall     = 1'b1;
      end
      // Load data lands in the register file this cycle; consumer reads it next cycle.
      STALL_WB: begin
        stall     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_flush) begin
      state_nxt = IDLE;
      stall     = 1'b0;
    end
    if (!reset_n) stall = 1'b0;
  end
`endif

  // NOTE: reset is synchronous; only control state and the counter need it, no memories here.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                         o_stall_count <= '0;
    else if (stall && o_stall_count != '1) o_stall_count <= o_stall_count + CNT_ONE;
  end

  assign o_stall  = stall;
  assign o_bubble = stall;
  assign o_fwd_rx = fwd_rx;
  assign o_fwd_ry = fwd_ry;

endmodule

// File: doc/ld_st_hazard_resolver.md
LD_ST_HAZARD_RESOLVER -- requirements
Module: ld_st_hazard_resolver

Interface
REQ-001 The block SHALL have parameter STALL_CNT_W, default 16, the width of the stall performance counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, a synchronous, active-low reset.
REQ-004 The block SHALL have port i_detect, input, 2, the LD/ST hazard vector from decode: bit0 means the ST data reg Rx[7:5] matches the execute destination; bit1 means the LD/ST address reg Ry[10:8] matches it.
REQ-005 The block SHALL have port i_ex_is_ld, input, 1, high when the execute-stage producer is OP_LD.
REQ-006 The block SHALL have port i_ex_result, input, 16, the execute-stage ALU/CALL write value.
REQ-007 The block SHALL have port i_mem_rdata, input, 16, the load data return.
REQ-008 The block SHALL have port i_mem_rdata_valid, input, 1, a one-cycle strobe qualifying i_mem_rdata.
REQ-009 The block SHALL have port i_flush, input, 1, taken-branch flush that kills the decode-stage consumer.
REQ-010 The block SHALL have port o_stall, output, 1, which holds the PC and the decode IR.
REQ-011 The block SHALL have port o_bubble, output, 1, which injects a NOP into execute.
REQ-012 The block SHALL have ports o_fwd_rx and o_fwd_ry, output, 1 each, the operand forward selects for the execute-stage consumer.
REQ-013 The block SHALL have port o_fwd_data, output, 16, the registered forward value.
REQ-014 The block SHALL have port o_stall_count, output, STALL_CNT_W, a saturating count of o_stall cycles.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT_MEM, FWD, and STALL_WB (STALL_WB exists only without the macro); state is encoded in registers.
REQ-016 In IDLE or FWD, when i_detect!=0 and i_ex_is_ld=0 (forwarding enabled), the block SHALL capture i_ex_result into o_fwd_data and a 2-bit mask from i_detect, then go to FWD; no stall.
REQ-017 In IDLE or FWD, when i_detect!=0 and i_ex_is_ld=1, the block SHALL assert o_stall=o_bubble=1 combinationally that cycle, latch the mask, and go to WAIT_MEM.
REQ-018 In WAIT_MEM, the block SHALL assert o_stall=o_bubble=1 while i_mem_rdata_valid=0.
REQ-019 In WAIT_MEM, on i_mem_rdata_valid=1 the block SHALL deassert stall/bubble that cycle, capture i_mem_rdata into o_fwd_data, and go to FWD.
REQ-020 In FWD, o_fwd_rx and o_fwd_ry SHALL equal the latched mask bits 0 and 1 for exactly one cycle; the block then returns to IDLE unless REQ-016/017 re-triggers.
REQ-021 In IDLE, o_fwd_rx/o_fwd_ry SHALL be 0; o_fwd_data holds its last value.
REQ-022 i_detect==0 in IDLE SHALL produce no output change.
REQ-023 i_flush=1 SHALL force next state IDLE and deassert o_stall/o_bubble in that cycle; this overrides every other transition, including simultaneous i_detect or i_mem_rdata_valid.
REQ-024 o_stall_count SHALL increment by 1 on each cycle with o_stall=1 and saturate at all-ones, never wrapping.

Reset
REQ-025 reset_n=0 at a clock edge SHALL force state IDLE, the mask to 0, o_fwd_data to 0, and o_stall_count to 0.
REQ-026 While reset_n=0, o_stall, o_bubble, o_fwd_rx, and o_fwd_ry SHALL all be 0.
REQ-027 A reset during WAIT_MEM SHALL abandon the pending load; a later i_mem_rdata_valid in IDLE SHALL be ignored.

Configuration
REQ-028 With macro HAZARD_FWD_EN defined, the block SHALL behave as REQ-016..REQ-020.
REQ-029 Without HAZARD_FWD_EN, o_fwd_rx=o_fwd_ry=0 and o_fwd_data=0 permanently.
REQ-030 Without HAZARD_FWD_EN, a non-LD hazard SHALL go to STALL_WB, with stall/bubble asserted for exactly 2 cycles (detect cycle plus one), then IDLE.
REQ-031 Without HAZARD_FWD_EN, a LD hazard SHALL wait in WAIT_MEM as in REQ-018, then spend 1 STALL_WB cycle with stall asserted, then go to IDLE.
REQ-032 REQ-023 through REQ-027 SHALL apply in both configurations.

Verification
REQ-033 The bench SHALL cover: FWD_EN, i_detect=2'b10, i_ex_is_ld=0, i_ex_result=16'h1234 -> no stall; next cycle o_fwd_ry=1, o_fwd_rx=0, o_fwd_data=16'h1234.
REQ-034 The bench SHALL cover: FWD_EN, i_detect=2'b11, i_ex_is_ld=1, rdata_valid 3 cycles later with 16'hBEEF -> o_stall high 3 cycles; then o_fwd_rx=o_fwd_ry=1, o_fwd_data=16'hBEEF; o_stall_count=3.
REQ-035 The bench SHALL cover: in WAIT_MEM, i_flush=1 together with i_mem_rdata_valid=1 -> IDLE, o_stall=0 that cycle, no forward next cycle.
REQ-036 The bench SHALL cover: reset_n=0 one cycle inside WAIT_MEM, then rdata_valid -> all outputs 0, o_stall_count=0, FSM stays IDLE.
REQ-037 The bench SHALL cover: no HAZARD_FWD_EN, non-LD detect -> o_stall=1 exactly 2 cycles; LD detect with data after 2 cycles -> o_stall=1 for 3 cycles total; o_fwd_* always 0.
REQ-038 The bench SHALL cover: STALL_CNT_W=4 with 20 consecutive stall cycles -> o_stall_count=4'hF, no wrap.
